seq_det_ctrl: RTL

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_match_core.sv | 51 +++++
 rtl/seq_det_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int PAT_W_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = 8;
    localparam int LEN_MIN       = 1;

    // A pattern length is usable only if it is non-zero and fits the history.
    function automatic logic len_legal(input logic [3:0] len, input int pat_w);
        return (int'(len) >= LEN_MIN) && (int'(len) <= pat_w);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, saturating fill counter and pattern compare.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       len,
    input  logic             overlap,
    output logic             match
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  history;
    logic [PAT_W-1:0]  history_next;
    logic [PAT_W-1:0]  mask;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;

    // The match looks at the history as it will be after this shift.
    always_comb begin
        history_next    = history << 1;
        history_next[0] = x;
        fill_next       = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
        mask            = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(len)) begin
                mask[i] = 1'b1;
            end
        end
        match = shift && (int'(fill_next) >= int'(len)) &&
                ((history_next & mask) == (pattern & mask));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            history <= '0;
            fill    <= '0;
        end else if (shift) begin
            history <= history_next;
            fill    <= (match && !overlap) ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Configurable serial sequence detector: config handshake, run control and match counting.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic             x_valid,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    logic [PAT_W-1:0] pattern_q;
    logic [3:0]       len_q;
    logic             overlap_q;
    logic [CNT_W-1:0] target_q;

    logic             cfg_xfer;
    logic             cfg_ok;
    logic             start_go;
    logic             shift;
    logic             match;
    logic [CNT_W-1:0] cnt_next;

    assign cfg_ready = (state != ST_RUN);
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);

    // A config transfer in the same cycle always shadows start; abort suppresses the shift.
    always_comb begin
        cfg_xfer = cfg_valid && cfg_ready;
        cfg_ok   = len_legal(cfg_len, PAT_W);
        start_go = start && !cfg_xfer && ((state == ST_ARMED) || (state == ST_DONE));
        shift    = (state == ST_RUN) && x_valid && !abort;
        cnt_next = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
    end

    seq_match_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_go),
        .shift   (shift),
        .x       (x),
        .pattern (pattern_q),
        .len     (len_q),
        .overlap (overlap_q),
        .match   (match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
            match_cnt <= '0;
            z         <= 1'b0;
            err       <= 1'b0;
        end else begin
            z   <= 1'b0;
            err <= 1'b0;
            case (state)
                ST_IDLE, ST_ARMED, ST_DONE: begin
                    if (cfg_xfer) begin
                        if (cfg_ok) begin
                            pattern_q <= cfg_pattern;
                            len_q     <= cfg_len;
                            overlap_q <= cfg_overlap;
                            target_q  <= cfg_target;
                            state     <= ST_ARMED;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (start_go) begin
                        match_cnt <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_ARMED;
                    end else if (match) begin
                        z         <= 1'b1;
                        match_cnt <= cnt_next;
                        if ((target_q != '0) && (cnt_next == target_q)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
